wb_forward_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/fwd_mux.sv | 39 +++
 rtl/wb_forward_unit.sv | 99 +++++++++
 tb/tb_wb_forward_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the stage tuple carried by the writer-side pipeline
// (MEM and WB registers, plus the EX-stage view handed to the bypass muxes).
package pipe_pkg;

    localparam int         WIDTH    = 64;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic        wr;
        logic        ld;
        logic [4:0]  rd;
        logic [63:0] res;
    } wb_stage_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority bypass selector for one read operand: XZR, then EX, MEM, WB, then
// the raw register-file value.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic [4:0]       rr,
    input  logic [WIDTH-1:0] raw,
    input  wb_stage_t        ex_s,
    input  wb_stage_t        mem_s,
    input  wb_stage_t        wb_s,
    output logic [WIDTH-1:0] operand
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // A tuple with ld set still has its value pending and cannot be bypassed.
    assign ex_hit  = ex_s.wr  & ~ex_s.ld  & (ex_s.rd  == rr);
    assign mem_hit = mem_s.wr & ~mem_s.ld & (mem_s.rd == rr);
    assign wb_hit  = wb_s.wr  & ~wb_s.ld  & (wb_s.rd  == rr);

    always_comb begin
        operand = raw;
        if (rr == ZERO_REG) begin
            operand = '0;
        end else if (ex_hit) begin
            operand = ex_s.res;
        end else if (mem_hit) begin
            operand = mem_s.res;
        end else if (wb_hit) begin
            operand = wb_s.res;
        end
    end

endmodule

// File: rtl/wb_forward_unit.sv
// Carries register writes from EX through MEM and WB to the register-file write
// port, bypasses in-flight results onto both read operands, flags load-use.
module wb_forward_unit
    import pipe_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_RegWrite,
    input  logic             ex_MemToReg,
    input  logic [4:0]       ex_Rd,
    input  logic [WIDTH-1:0] ex_Result,
    input  logic             flush,
    input  logic [WIDTH-1:0] mem_LoadData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    output logic [WIDTH-1:0] Operand1,
    output logic [WIDTH-1:0] Operand2,
    output logic             Stall,
    output logic [4:0]       WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    output logic             RegWrite
);

    wb_stage_t mem_d, mem_q;
    wb_stage_t wb_d,  wb_q;
    wb_stage_t ex_s;
    wb_stage_t mem_s;
    logic [WIDTH-1:0] mem_val;
    logic ex_live;

    assign ex_live = ex_RegWrite & ~flush;
    assign mem_val = mem_q.ld ? mem_LoadData : mem_q.res;

    always_comb begin
        mem_d.wr  = ex_live & (ex_Rd != ZERO_REG);
        mem_d.ld  = ex_MemToReg & ex_live & (ex_Rd != ZERO_REG);
        mem_d.rd  = ex_Rd;
        mem_d.res = ex_Result;

        // Load data is resolved by the time it reaches WB, so ld is dropped.
        wb_d.wr  = mem_q.wr;
        wb_d.ld  = 1'b0;
        wb_d.rd  = mem_q.rd;
        wb_d.res = mem_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{wr: 1'b0, ld: 1'b0, rd: ZERO_REG, res: '0};
            wb_q  <= '{wr: 1'b0, ld: 1'b0, rd: ZERO_REG, res: '0};
        end else begin
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    always_comb begin
        ex_s.wr   = ex_live;
        ex_s.ld   = ex_MemToReg;
        ex_s.rd   = ex_Rd;
        ex_s.res  = ex_Result;

        mem_s.wr  = mem_q.wr;
        mem_s.ld  = 1'b0;
        mem_s.rd  = mem_q.rd;
        mem_s.res = mem_val;
    end

    fwd_mux #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_fwd1 (
        .rr      (ReadRegister1),
        .raw     (ReadData1),
        .ex_s    (ex_s),
        .mem_s   (mem_s),
        .wb_s    (wb_q),
        .operand (Operand1)
    );

    fwd_mux #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_fwd2 (
        .rr      (ReadRegister2),
        .raw     (ReadData2),
        .ex_s    (ex_s),
        .mem_s   (mem_s),
        .wb_s    (wb_q),
        .operand (Operand2)
    );

    assign Stall = ex_live & ex_MemToReg & (ex_Rd != ZERO_REG) &
                   ((ex_Rd == ReadRegister1) | (ex_Rd == ReadRegister2));

    assign RegWrite      = wb_q.wr;
    assign WriteRegister = wb_q.rd;
    assign WriteData     = wb_q.res;

endmodule

// File: tb/tb_wb_forward_unit.sv
// Directed bench for wb_forward_unit: write-back latency, bypass priority,
// load-use stall, XZR/flush suppression and mid-pipeline reset.
module tb_wb_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_RegWrite;
    logic        ex_MemToReg;
    logic [4:0]  ex_Rd;
    logic [63:0] ex_Result;
    logic        flush;
    logic [63:0] mem_LoadData;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [63:0] ReadData1, ReadData2;
    logic [63:0] Operand1, Operand2;
    logic        Stall;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_forward_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ex_RegWrite   (ex_RegWrite),
        .ex_MemToReg   (ex_MemToReg),
        .ex_Rd         (ex_Rd),
        .ex_Result     (ex_Result),
        .flush         (flush),
        .mem_LoadData  (mem_LoadData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Operand1      (Operand1),
        .Operand2      (Operand2),
        .Stall         (Stall),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_RegWrite = 1'b0;
        ex_MemToReg = 1'b0;
        ex_Rd       = 5'd0;
        ex_Result   = '0;
        flush       = 1'b0;
    endtask

    task automatic ex_write(input logic [4:0] rd, input logic [63:0] res, input logic ld);
        ex_RegWrite = 1'b1;
        ex_MemToReg = ld;
        ex_Rd       = rd;
        ex_Result   = res;
    endtask

    initial begin
        reset = 1'b1;
        ex_idle();
        mem_LoadData  = '0;
        ReadRegister1 = 5'd1;
        ReadRegister2 = 5'd2;
        ReadData1     = 64'hA5;
        ReadData2     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state, idle
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_wreg", {59'd0, WriteRegister}, 64'd31);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_stall", {63'd0, Stall}, 64'd0);
        chk("rst_op1_raw", Operand1, 64'hA5);

        // ALU write X3 = 0x10 through EX, MEM, WB
        ReadRegister1 = 5'd3;
        ReadData1     = 64'd0;
        ex_write(5'd3, 64'h10, 1'b0);
        #1;
        chk("x3_ex_fwd", Operand1, 64'h10);
        tick();
        ex_idle();
        #1;
        chk("x3_mem_fwd", Operand1, 64'h10);
        chk("x3_mem_regwrite", {63'd0, RegWrite}, 64'd0);
        tick();
        chk("x3_wb_regwrite", {63'd0, RegWrite}, 64'd1);
        chk("x3_wb_wreg", {59'd0, WriteRegister}, 64'd3);
        chk("x3_wb_wdata", WriteData, 64'h10);
        chk("x3_wb_fwd", Operand1, 64'h10);
        tick();
        chk("x3_retired_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("x3_retired_raw", Operand1, 64'd0);

        // Back-to-back X5=1, X5=2
        ex_write(5'd5, 64'd1, 1'b0);
        tick();
        ex_write(5'd5, 64'd2, 1'b0);
        ReadRegister1 = 5'd5;
        #1;
        chk("x5_ex_beats_mem", Operand1, 64'd2);
        tick();
        ex_idle();
        #1;
        chk("x5_mem_beats_wb", Operand1, 64'd2);
        tick();
        chk("x5_wb_data", WriteData, 64'd2);
        tick();

        // Load X7 with ReadRegister2 = 7: load-use stall, then load data forwarded
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd7;
        ReadData2     = 64'h55;
        ex_write(5'd7, 64'h99, 1'b1);
        #1;
        chk("ld7_stall", {63'd0, Stall}, 64'd1);
        chk("ld7_ex_no_fwd", Operand2, 64'h55);
        tick();
        ex_idle();
        mem_LoadData = 64'hDEAD;
        #1;
        chk("ld7_mem_fwd", Operand2, 64'hDEAD);
        chk("ld7_bubble_stall", {63'd0, Stall}, 64'd0);
        tick();
        mem_LoadData = 64'h0;
        #1;
        chk("ld7_wb_regwrite", {63'd0, RegWrite}, 64'd1);
        chk("ld7_wb_wreg", {59'd0, WriteRegister}, 64'd7);
        chk("ld7_wb_wdata", WriteData, 64'hDEAD);
        tick();

        // Flushed load into ReadRegister1 must not stall
        ReadRegister1 = 5'd8;
        ex_write(5'd8, 64'h0, 1'b1);
        flush = 1'b1;
        #1;
        chk("ld8_flush_stall", {63'd0, Stall}, 64'd0);
        tick();
        ex_idle();
        tick();
        chk("ld8_flush_regwrite", {63'd0, RegWrite}, 64'd0);

        // Write to XZR
        ReadRegister1 = 5'd31;
        ReadData1     = 64'h77;
        ex_write(5'd31, 64'hFF, 1'b0);
        #1;
        chk("x31_ex_zero", Operand1, 64'd0);
        chk("x31_stall", {63'd0, Stall}, 64'd0);
        tick();
        ex_idle();
        #1;
        chk("x31_mem_zero", Operand1, 64'd0);
        tick();
        chk("x31_regwrite", {63'd0, RegWrite}, 64'd0);

        // Flushed write to X4
        ReadRegister1 = 5'd4;
        ReadData1     = 64'h44;
        ex_write(5'd4, 64'hAB, 1'b0);
        flush = 1'b1;
        #1;
        chk("x4_flush_ex", Operand1, 64'h44);
        tick();
        ex_idle();
        #1;
        chk("x4_flush_mem", Operand1, 64'h44);
        tick();
        chk("x4_flush_regwrite", {63'd0, RegWrite}, 64'd0);

        // Both operands naming the same in-flight register
        ReadRegister1 = 5'd12;
        ReadRegister2 = 5'd12;
        ReadData1     = 64'h1;
        ReadData2     = 64'h2;
        ex_write(5'd12, 64'hC0FFEE, 1'b0);
        #1;
        chk("x12_op1", Operand1, 64'hC0FFEE);
        chk("x12_op2", Operand2, 64'hC0FFEE);
        tick();
        ex_idle();
        tick();
        tick();

        // X9 in flight, reset asserted in its MEM cycle
        ReadRegister1 = 5'd9;
        ReadData1     = 64'h1234;
        ex_write(5'd9, 64'h99, 1'b0);
        tick();
        ex_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("x9_reset_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("x9_reset_wreg", {59'd0, WriteRegister}, 64'd31);
        chk("x9_reset_raw", Operand1, 64'h1234);
        tick();
        chk("x9_after_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("x9_after_raw", Operand1, 64'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
